// File: rtl/matrix_spi_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_pkg
// Purpose  : Shared types, counter-width helpers and frame-length arithmetic
//            for the matrix SPI streamer.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Bit-within-byte counter always counts 0..7.
  localparam int BIT_CNT_W = 3;

  // Phase counter must hold 0..SCK_DIV-1 and never wrap.
  function automatic int phase_cnt_w(input int sck_div);
    return $clog2(sck_div + 1);
  endfunction

  // Latency counter saturates at READ_LATENCY, so it needs one extra code.
  function automatic int lat_cnt_w(input int read_latency);
    return $clog2(read_latency + 1);
  endfunction

  // Cycles from the edge that accepts I_start to the O_frame_done cycle,
  // counting the start cycle itself.
  function automatic int frame_cycles(input int bytes, input int sck_div,
                                      input int read_latency);
    return 1 + read_latency + bytes * 16 * sck_div + sck_div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_spi_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_spi_streamer_if
// Purpose  : Buffer read port, frame control and SPI pin bundle for the
//            matrix SPI streamer. master = streamer, slave = environment.
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_spi_streamer_if #(
  parameter int CHANNELS = 12,
  parameter int ADDR_W   = 12
) ();

  logic                  I_start;
  logic                  I_data_valid;
  logic [ADDR_W-1:0]     O_read_address;
  logic [CHANNELS*8-1:0] I_data_flat;
  logic                  O_sck;
  logic [CHANNELS-1:0]   O_mosi;
  logic                  O_cs_n;
  logic                  O_busy;
  logic                  O_frame_done;

  modport master (
    input  I_start, I_data_valid, I_data_flat,
    output O_read_address, O_sck, O_mosi, O_cs_n, O_busy, O_frame_done
  );

  modport slave (
    output I_start, I_data_valid, I_data_flat,
    input  O_read_address, O_sck, O_mosi, O_cs_n, O_busy, O_frame_done
  );

endinterface
`default_nettype wire

// File: rtl/matrix_spi_streamer_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_channel_shifter
// Purpose  : Per-channel byte shift register plus prefetch holding register.
//            MSB of the shift register drives the channel MOSI line.
// Revision : 1.0 - initial release
// ============================================================================
module spi_channel_shifter (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic       clr_i,
  input  wire logic       load_i,
  input  wire logic       capture_i,
  input  wire logic       xfer_i,
  input  wire logic       shift_i,
  input  wire logic [7:0] data_i,
  output logic            msb_o
);

  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;

  // Next-state: direct load beats transfer beats shift; capture is independent.
  always_comb begin
    shift_d = shift_q;
    hold_d  = hold_q;
    if (capture_i) hold_d = data_i;
    if (load_i) begin
      shift_d = data_i;
    end else if (xfer_i) begin
      shift_d = hold_q;
    end else if (shift_i) begin
      shift_d = {shift_q[6:0], 1'b0};
    end
  end

  // Register update; clear drops both registers so MOSI idles low.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      shift_q <= '0;
      hold_q  <= '0;
    end else begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
    end
  end

  assign msb_o = shift_q[7];

endmodule
`default_nettype wire

// File: rtl/matrix_spi_streamer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_spi_streamer
// Purpose  : Walks the frame-store read address through one frame and
//            streams one byte per channel per address onto parallel SPI
//            MOSI lines with shared SCK (mode 0) and CS_n.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_spi_streamer
  import matrix_stream_pkg::*;
#(
  parameter int CHANNELS        = 12,
  parameter int BYTES_PER_FRAME = 2250,
  parameter int ADDR_W          = $clog2(BYTES_PER_FRAME),
  parameter int SCK_DIV         = 4,
  parameter int READ_LATENCY    = 2
) (
  input  wire logic             I_clk,
  input  wire logic             I_rst,
  matrix_spi_streamer_if.master bus
);

  localparam int PH_W  = phase_cnt_w(SCK_DIV);
  localparam int LAT_W = lat_cnt_w(READ_LATENCY);

  localparam logic [ADDR_W-1:0]    LAST_BYTE  = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [ADDR_W-1:0]    FIRST_NEXT = (BYTES_PER_FRAME > 1) ? ADDR_W'(1) : '0;
  localparam logic [PH_W-1:0]      PH_LAST    = PH_W'(SCK_DIV - 1);
  localparam logic [LAT_W-1:0]     LAT_LAST   = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]     LAT_MAX    = LAT_W'(READ_LATENCY);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(7);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      byte_q, byte_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   sck_q, sck_d;
  logic                   cs_n_q, cs_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   load_en, cap_en, xfer_en, shift_en, clr_en;
  logic [CHANNELS-1:0]    mosi;

  // Next-state and shifter control; lat_q counts LOAD cycles, then the
  // cycles since the current byte began (saturating) to time the prefetch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    lat_d    = lat_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    cap_en   = 1'b0;
    xfer_en  = 1'b0;
    shift_en = 1'b0;
    clr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.I_start && bus.I_data_valid) begin
          state_d = LOAD;
          addr_d  = '0;
          lat_d   = '0;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_LAST) begin
          load_en = 1'b1;
          addr_d  = FIRST_NEXT;
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
          lat_d   = '0;
        end
      end

      SHIFT: begin
        if (lat_q != LAT_MAX) lat_d = lat_q + LAT_W'(1);
        // Data for the next byte's address is valid READ_LATENCY cycles in.
        if (lat_q == LAT_LAST && byte_q != LAST_BYTE) cap_en = 1'b1;
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              if (byte_q == LAST_BYTE) begin
                // Final shift empties the register so MOSI is low in HOLD.
                state_d  = HOLD;
                shift_en = 1'b1;
              end else begin
                xfer_en = 1'b1;
                byte_d  = byte_q + ADDR_W'(1);
                bit_d   = '0;
                lat_d   = '0;
                if (addr_q != LAST_BYTE) addr_d = addr_q + ADDR_W'(1);
              end
            end else begin
              bit_d    = bit_q + BIT_CNT_W'(1);
              shift_en = 1'b1;
            end
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      HOLD: begin
        if (ph_q == PH_LAST) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = '0;
          done_d  = 1'b1;
          clr_en  = 1'b1;
          ph_d    = '0;
          lat_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      lat_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      lat_q   <= lat_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    spi_channel_shifter u_shifter (
      .clk_i     (I_clk),
      .rst_i     (I_rst),
      .clr_i     (clr_en),
      .load_i    (load_en),
      .capture_i (cap_en),
      .xfer_i    (xfer_en),
      .shift_i   (shift_en),
      .data_i    (bus.I_data_flat[c*8 +: 8]),
      .msb_o     (mosi[c])
    );
  end

  assign bus.O_read_address = addr_q;
  assign bus.O_sck          = sck_q;
  assign bus.O_mosi         = mosi;
  assign bus.O_cs_n         = cs_n_q;
  assign bus.O_busy         = busy_q;
  assign bus.O_frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_spi_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_spi_streamer
// Purpose  : Self-checking bench: random frame contents streamed out and
//            compared with the frame store, plus timing/control scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_spi_streamer;
  import matrix_stream_pkg::*;

  localparam int CH = 2;
  localparam int NB = 3;
  localparam int SD = 2;
  localparam int RL = 2;
  localparam int AW = $clog2(NB);
  localparam int FRAME_LEN = frame_cycles(NB, SD, RL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_spi_streamer_if #(.CHANNELS(CH), .ADDR_W(AW)) bus ();

  matrix_spi_streamer #(
    .CHANNELS        (CH),
    .BYTES_PER_FRAME (NB),
    .ADDR_W          (AW),
    .SCK_DIV         (SD),
    .READ_LATENCY    (RL)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // Frame store model: synchronous read, so data for an address registered
  // at edge k is presented after edge k+1 and sampled at edge k+2.
  logic [7:0]      mem [CH][NB];
  logic [CH*8-1:0] rd_q = '0;

  function automatic logic [7:0] rd_byte(input int c, input int a);
    return (a < NB) ? mem[c][a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++)
      rd_q[c*8 +: 8] <= rd_byte(c, int'(bus.O_read_address));
  end
  assign bus.I_data_flat = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cs_n"}, 32'(bus.O_cs_n), 1);
    check_eq({tag, "_sck"},  32'(bus.O_sck), 0);
    check_eq({tag, "_mosi"}, 32'(bus.O_mosi), 0);
    check_eq({tag, "_busy"}, 32'(bus.O_busy), 0);
    check_eq({tag, "_addr"}, 32'(bus.O_read_address), 0);
    check_eq({tag, "_done"}, 32'(bus.O_frame_done), 0);
  endtask

  task automatic fill_fixed();
    mem[0][0] = 8'hA5; mem[0][1] = 8'h3C; mem[0][2] = 8'hFF;
    mem[1][0] = 8'h01; mem[1][1] = 8'h80; mem[1][2] = 8'h7E;
  endtask

  task automatic fill_random();
    for (int c = 0; c < CH; c++)
      for (int b = 0; b < NB; b++)
        mem[c][b] = 8'($urandom);
  endtask

  // Runs one frame from the start cycle to O_frame_done, observing the pins
  // the way a slave would. Called at a negedge. extra_start / drop_valid are
  // cycle numbers (0 = unused). chain_next raises I_start in the done cycle.
  task automatic run_frame(input string tag, input bit pre_started,
                           input int extra_start, input int drop_valid,
                           input bit chain_next);
    int cyc = 0, rises = 0, last_rise = -1, min_iv = 1000, max_iv = 0;
    int done_cyc = -1, cs_low = 0, cs_glitch = 0, unstable = 0, high_cyc = 0;
    int tail_busy = 0, tail_done = 0;
    bit cs_seen = 0, prev_sck = 0;
    logic [CH-1:0] prev_mosi = '0;
    logic [31:0]   addr_seq[$];
    logic [7:0]    got [CH][NB];
    for (int c = 0; c < CH; c++)
      for (int b = 0; b < NB; b++) got[c][b] = '0;

    if (!pre_started) begin
      bus.I_start      = 1'b1;
      bus.I_data_valid = 1'b1;
    end
    while (cyc < FRAME_LEN + 20 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      bus.I_start = (cyc == extra_start);
      if (cyc == drop_valid) bus.I_data_valid = 1'b0;
      if (cyc == 1) check_eq({tag, "_busy_rise"}, 32'(bus.O_busy), 1);
      if (addr_seq.size() == 0 || addr_seq[$] != 32'(bus.O_read_address))
        addr_seq.push_back(32'(bus.O_read_address));
      if (bus.O_sck && !prev_sck) begin
        if (bus.O_mosi != prev_mosi) unstable++;
        if (rises < NB * 8)
          for (int c = 0; c < CH; c++)
            got[c][rises / 8][7 - rises % 8] = bus.O_mosi[c];
        if (last_rise >= 0) begin
          if (cyc - last_rise < min_iv) min_iv = cyc - last_rise;
          if (cyc - last_rise > max_iv) max_iv = cyc - last_rise;
        end
        last_rise = cyc;
        rises++;
      end
      if (bus.O_sck) high_cyc++;
      if (!bus.O_cs_n) begin
        cs_low++;
        cs_seen = 1'b1;
      end else if (cs_seen && !bus.O_frame_done) begin
        cs_glitch++;
      end
      if (bus.O_frame_done) begin
        done_cyc = cyc;
        check_eq({tag, "_done_cs_n"}, 32'(bus.O_cs_n), 1);
        check_eq({tag, "_done_busy"}, 32'(bus.O_busy), 0);
        check_eq({tag, "_done_mosi"}, 32'(bus.O_mosi), 0);
        if (chain_next) bus.I_start = 1'b1;
      end
      prev_sck  = bus.O_sck;
      prev_mosi = bus.O_mosi;
    end

    check_eq({tag, "_latency"}, 32'(done_cyc), 32'(FRAME_LEN));
    check_eq({tag, "_sck_rises"}, 32'(rises), 32'(NB * 8));
    check_eq({tag, "_sck_high_cycles"}, 32'(high_cyc), 32'(NB * 8 * SD));
    check_eq({tag, "_rise_iv_min"}, 32'(min_iv), 32'(2 * SD));
    check_eq({tag, "_rise_iv_max"}, 32'(max_iv), 32'(2 * SD));
    check_eq({tag, "_mosi_unstable"}, 32'(unstable), 0);
    check_eq({tag, "_cs_low_cycles"}, 32'(cs_low), 32'(NB * 16 * SD + SD));
    check_eq({tag, "_cs_glitch"}, 32'(cs_glitch), 0);
    check_eq({tag, "_addr_seq_len"}, 32'(addr_seq.size()), 32'(NB + 1));
    for (int i = 0; i < addr_seq.size() && i <= NB; i++)
      check_eq({tag, $sformatf("_addr_seq%0d", i)}, addr_seq[i],
               (i < NB) ? 32'(i) : 32'd0);
    for (int c = 0; c < CH; c++)
      for (int b = 0; b < NB; b++)
        check_eq({tag, $sformatf("_ch%0d_byte%0d", c, b)}, 32'(got[c][b]),
                 32'(mem[c][b]));

    if (!chain_next) begin
      repeat (30) begin
        @(negedge clk);
        bus.I_start = 1'b0;
        if (bus.O_busy) tail_busy++;
        if (bus.O_frame_done) tail_done++;
      end
      check_eq({tag, "_tail_busy"}, 32'(tail_busy), 0);
      check_eq({tag, "_tail_done"}, 32'(tail_done), 0);
    end
  endtask

  initial begin
    int cnt_busy, cnt_cs, cnt_done;
    bus.I_start      = 1'b0;
    bus.I_data_valid = 1'b0;
    fill_fixed();

    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Start without valid data is ignored.
    bus.I_start = 1'b1;
    @(negedge clk);
    bus.I_start = 1'b0;
    cnt_busy = 0;
    cnt_cs   = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.O_busy) cnt_busy++;
      if (!bus.O_cs_n) cnt_cs++;
    end
    check_eq("novalid_busy", 32'(cnt_busy), 0);
    check_eq("novalid_cs", 32'(cnt_cs), 0);

    // Known pattern, then a start while busy that must be dropped and a
    // start in the done cycle that must be accepted.
    run_frame("basic", 1'b0, 0, 0, 1'b0);
    fill_random();
    run_frame("busy_start", 1'b0, 40, 0, 1'b1);
    fill_random();
    run_frame("chained", 1'b1, 0, 60, 1'b0);

    for (int i = 0; i < 4; i++) begin
      fill_random();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame($sformatf("rand%0d", i), 1'b0,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 95)) : 0,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 95)) : 0,
                1'b0);
    end

    // Reset in the middle of byte 1.
    fill_fixed();
    bus.I_start      = 1'b1;
    bus.I_data_valid = 1'b1;
    @(negedge clk);
    bus.I_start = 1'b0;
    repeat (1 + RL + 16 * SD + 4) @(negedge clk);
    check_eq("midrst_pre_busy", 32'(bus.O_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    cnt_busy = 0;
    cnt_done = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.O_busy) cnt_busy++;
      if (bus.O_frame_done) cnt_done++;
    end
    check_eq("midrst_busy_after", 32'(cnt_busy), 0);
    check_eq("midrst_no_done", 32'(cnt_done), 0);
    run_frame("after_rst", 1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_spi_streamer.md
Name: matrix_spi_streamer

Overview:
- Read-side consumer of the double-buffered matrix frame store.
- Walks the shared byte read address through one full frame and captures one byte per channel from the buffer's flat read data.
- Serializes all channels in parallel onto per-channel MOSI lines with a common SCK and CS_n, feeding the ch32v003 matrix controllers.
- Sits between the buffer read port and the FPGA output pins, in the read clock domain.

Parameters:
- CHANNELS, 12: parallel SPI data lines, equal to bank count × block count.
- BYTES_PER_FRAME, 2250: bytes per channel per frame.
- ADDR_W, $clog2(BYTES_PER_FRAME): read address width.
- SCK_DIV, 4: clock cycles per SCK half-period. Must be ≥ 1.
- READ_LATENCY, 2: cycles from a registered address to valid buffer data. Must be in 1 .. 2*SCK_DIV*8-1.

Ports:
- I_clk, input, 1: read-side clock, the only clock.
- I_rst, input, 1: synchronous reset, active-high.
- I_start, input, 1: one-cycle frame start request.
- I_data_valid, input, 1: buffer holds a valid frame (high after the first swap).
- O_read_address, output, ADDR_W: common byte address to the buffer read port.
- I_data_flat, input, CHANNELS*8: buffer read data. Channel c occupies bits [c*8 +: 8].
- O_sck, output, 1: SPI clock, mode 0 (idle low, sampled on rising edge).
- O_mosi, output, CHANNELS: per-channel serial data, MSB first.
- O_cs_n, output, 1: common chip select, active low.
- O_busy, output, 1: high from LOAD entry until return to IDLE.
- O_frame_done, output, 1: one-cycle pulse when the frame completes.

Behaviour:
- Reset (I_rst sampled high): next cycle state=IDLE, O_read_address=0, O_sck=0, O_mosi=0, O_cs_n=1, O_busy=0, O_frame_done=0. All counters and shift/holding registers are cleared.
- Reset has priority over every other input, including mid-frame. There is no partial-frame completion and no O_frame_done pulse.
- All outputs are registered.
- IDLE:
  - I_start && I_data_valid → LOAD. O_read_address=0 and O_busy=1 from the next cycle.
  - I_start while !I_data_valid is ignored.
- LOAD:
  - Lasts READ_LATENCY cycles. On the last cycle, I_data_flat is captured into the per-channel shift registers.
  - O_read_address advances to 1 (if BYTES_PER_FRAME > 1) on that same edge → SHIFT.
- SHIFT:
  - O_cs_n=0 throughout.
  - Each bit is SCK_DIV cycles with O_sck=0, then SCK_DIV cycles with O_sck=1.
  - O_mosi[c] = shift_reg[c][7] and updates only on entry to a low phase. It is stable across the rising edge.
  - Prefetch: READ_LATENCY cycles after each byte's first low phase begins, I_data_flat is captured into holding registers for the next byte.
  - At the end of bit 0's high phase, the holding registers are transferred to the shift registers and O_read_address increments. There is no SCK gap between bytes.
  - After byte BYTES_PER_FRAME-1: no prefetch capture, and O_read_address holds at BYTES_PER_FRAME-1 (no wrap). At the end of its bit 0 high phase → HOLD.
- HOLD:
  - SCK_DIV cycles with O_sck=0 and O_cs_n=0.
  - Then → IDLE with O_cs_n=1, O_busy=0, O_read_address=0, O_mosi=0, and O_frame_done=1 for exactly that cycle.
- I_start while busy is ignored, not queued. I_start in the cycle O_frame_done is high is accepted, since the state is IDLE.
- I_data_valid falling mid-frame is ignored; the frame completes.
- Frame length from the accepting edge to O_frame_done: 1 + READ_LATENCY + BYTES_PER_FRAME*16*SCK_DIV + SCK_DIV cycles.
- Arithmetic:
  - Byte counter is ADDR_W wide and compares against BYTES_PER_FRAME-1.
  - Bit counter is 3 bits.
  - Phase counter is $clog2(SCK_DIV+1) bits.
  - No counter ever wraps inside a frame.

Decomposition:
- matrix_stream_pkg holds:
  - state_t enum: IDLE, LOAD, SHIFT, HOLD.
  - localparam helpers for counter widths.
  - the frame-length function used by the bench.
- Sub-module spi_channel_shifter: one per channel via generate. It contains the 8-bit shift register and holding register, with load, transfer and shift enables driven by the top FSM. Output is the MSB.

Test Plan:
- Reset: hold I_rst 3 cycles → O_cs_n=1, O_sck=0, O_mosi=0, O_busy=0, O_read_address=0, O_frame_done=0.
- Start without valid: I_data_valid=0, pulse I_start → O_busy stays 0 and O_cs_n stays 1 for 100 cycles.
- Basic frame:
  - Config: CHANNELS=2, BYTES_PER_FRAME=3, SCK_DIV=2, READ_LATENCY=2. Memory model: ch0 = A5,3C,FF; ch1 = 01,80,7E.
  - Pulse start → 24 rising SCK edges sample ch0 = A5 3C FF and ch1 = 01 80 7E, MSB first.
  - O_frame_done arrives 1+2+96+2=101 cycles after the start edge.
  - Address sequence 0,1,2, then 0.
- Continuity: same config → the interval between consecutive SCK rising edges is exactly 4 cycles across byte boundaries. O_cs_n stays low from the first low phase to the end of HOLD.
- Start while busy: second I_start at cycle 40 → ignored, only one O_frame_done. I_start in the O_frame_done cycle → a new frame starts and O_busy rises on the next cycle.
- Mid-frame reset: assert I_rst during byte 1 → idle outputs the next cycle, no O_frame_done. A following start restarts at address 0 and outputs A5 first.
